// File: rtl/mcu_pkg.sv
// Shared definitions for the microcontroller core: widths, opcodes and the
// fetch-side loader state encoding.
package mcu_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 8;

    localparam logic [3:0] NOP   = 4'h0;
    localparam logic [3:0] ADD   = 4'h1;
    localparam logic [3:0] SUB   = 4'h2;
    localparam logic [3:0] NOR   = 4'h3;
    localparam logic [3:0] MOVRA = 4'h4;
    localparam logic [3:0] MOVAR = 4'h5;
    localparam logic [3:0] JZR   = 4'h6;
    localparam logic [3:0] JZI   = 4'h7;
    localparam logic [3:0] JCR   = 4'h8;
    localparam logic [3:0] JCI   = 4'hA;
    localparam logic [3:0] SHL   = 4'hB;
    localparam logic [3:0] SHR   = 4'hC;
    localparam logic [3:0] LDIMM = 4'hD;
    localparam logic [3:0] HALT  = 4'hF;

    localparam logic [INSTR_W-1:0] NOP_WORD = 8'h00;

    typedef enum logic [1:0] {
        StRun,
        StLoad,
        StFlush
    } ld_state_e;

endpackage

// File: rtl/prog_mem.sv
// Program memory: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module prog_mem #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: program counter, instruction register and a loader FSM that
// refills program memory from a valid/ready byte stream while the core is stalled.
module fetch_unit #(
    parameter int unsigned PC_W    = mcu_pkg::PC_W,
    parameter int unsigned DEPTH   = 2 ** PC_W,
    parameter int unsigned INSTR_W = mcu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               clb,
    input  logic               incPC,
    input  logic               loadPC,
    input  logic               selPC,
    input  logic               loadIR,
    input  logic [PC_W-1:0]    rs_data,
    input  logic               load_start,
    input  logic               load_end,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               ld_ready,
    output logic [PC_W-1:0]    pc,
    output logic [3:0]         opcode,
    output logic [3:0]         operand,
    output logic               busy,
    output logic [PC_W:0]      ld_count
);

    import mcu_pkg::*;

    localparam int unsigned CNT_W = PC_W + 1;

    ld_state_e          state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]    wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]   ld_count_q, ld_count_d;
    logic               mem_we;
    logic [INSTR_W-1:0] mem_rdata;

    prog_mem #(
        .ADDR_W (PC_W),
        .DEPTH  (DEPTH),
        .DATA_W (INSTR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr_q),
        .wdata (ld_data),
        .raddr (pc_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge clb) begin
        if (clb) begin
            state_q    <= StRun;
            pc_q       <= '0;
            ir_q       <= NOP_WORD;
            wr_addr_q  <= '0;
            ld_count_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            wr_addr_q  <= wr_addr_d;
            ld_count_q <= ld_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        wr_addr_d  = wr_addr_q;
        ld_count_d = ld_count_q;
        mem_we     = 1'b0;

        unique case (state_q)
            StRun: begin
                if (load_start) begin
                    state_d    = StLoad;
                    wr_addr_d  = '0;
                    ld_count_d = '0;
                    ir_d       = NOP_WORD;
                end else begin
                    if (loadIR) begin
                        ir_d = mem_rdata;
                    end
                    // Jump beats increment; the immediate form stays within the current page.
                    if (loadPC) begin
                        pc_d = selPC ? rs_data : {pc_q[PC_W-1:4], ir_q[3:0]};
                    end else if (incPC) begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            StLoad: begin
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    wr_addr_d = wr_addr_q + PC_W'(1);
                    if (ld_count_q != CNT_W'(DEPTH)) begin
                        ld_count_d = ld_count_q + CNT_W'(1);
                    end
                end
                if (load_end || (ld_valid && (wr_addr_q == PC_W'(DEPTH - 1)))) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                pc_d    = '0;
                ir_d    = NOP_WORD;
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    assign ld_ready = (state_q == StLoad);
    assign busy     = (state_q != StRun);
    assign pc       = pc_q;
    assign opcode   = ir_q[INSTR_W-1:INSTR_W-4];
    assign operand  = ir_q[3:0];
    assign ld_count = ld_count_q;

endmodule
